pkt_sche_mq: RTL

PKT_SCHE_MQ -- requirements
Module: pkt_sche_mq

---
 rtl/pkt_sche_mq_if.sv | 33 +++
 rtl/pkt_sche_mq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pkt_sche_mq_if.sv
// Handshake bundle between the multi-queue scheduler and its producer/consumer.
// The slave modport is the scheduler side.
interface pkt_sche_mq_if #(
    parameter int DWIDTH    = 32,
    parameter int NUM_CLASS = 4
);
    localparam int CW = $clog2(NUM_CLASS);

    logic              ready;
    logic              in_enque_en;
    logic              in_ugr_en;
    logic [CW-1:0]     in_class;
    logic [DWIDTH-1:0] in_data;
    logic              in_accept;
    logic              out_valid;
    logic              out_deque_en;
    logic [DWIDTH-1:0] out_data;
    logic [CW-1:0]     out_class;
    logic              out_ugr;
    logic [15:0]       drop_cnt;

    modport slave (
        input  in_enque_en, in_ugr_en, in_class, in_data, out_deque_en,
        output ready, in_accept, out_valid, out_data, out_class, out_ugr,
        drop_cnt
    );

    modport master (
        output in_enque_en, in_ugr_en, in_class, in_data, out_deque_en,
        input  ready, in_accept, out_valid, out_data, out_class, out_ugr,
        drop_cnt
    );
endinterface

// File: rtl/pkt_sche_mq.sv
// Multi-queue packet scheduler: per-class FIFOs plus an urgent FIFO feeding
// a single output register, strict-priority or round-robin between classes.
module pkt_sche_mq #(
    parameter int DWIDTH      = 32,
    parameter int NUM_CLASS   = 4,
    parameter int QUEUE_DEPTH = 16,
    parameter int MODE        = 0
) (
    input  logic         clk,
    input  logic         rst,
    pkt_sche_mq_if.slave bus
);
    localparam int CW   = $clog2(NUM_CLASS);
    localparam int NQ   = NUM_CLASS + 1;
    localparam int QW   = $clog2(NQ);
    localparam int AW   = $clog2(QUEUE_DEPTH);
    localparam int CNTW = AW + 1;

    localparam logic [AW-1:0]   P_ONE  = 1;
    localparam logic [AW:0]     C_ONE  = 1;
    localparam logic [AW:0]     C_FULL = CNTW'(QUEUE_DEPTH);
    localparam logic [CW-1:0]   R_ONE  = 1;
    localparam logic [QW-1:0]   UQ     = QW'(NUM_CLASS);

    // Queue NUM_CLASS is the urgent queue.
    logic [DWIDTH-1:0] mem [NQ][QUEUE_DEPTH];

    logic [AW-1:0]     wr_ptr_q [NQ];
    logic [AW-1:0]     wr_ptr_d [NQ];
    logic [AW-1:0]     rd_ptr_q [NQ];
    logic [AW-1:0]     rd_ptr_d [NQ];
    logic [AW:0]       cnt_q    [NQ];
    logic [AW:0]       cnt_d    [NQ];
    logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [15:0]       drop_q, drop_d;
    logic              ready_q, ready_d;
    logic              out_valid_q, out_valid_d;
    logic              out_ugr_q, out_ugr_d;
    logic [DWIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]     out_class_q, out_class_d;

    logic [CW-1:0]     cls;
    logic [QW-1:0]     tgt;
    logic [QW-1:0]     sel;
    logic [NQ-1:0]     nonempty;
    logic              full, accept, push, load, found;
    logic              push_i, pop_i;
    int                idx;

    always_comb begin
        cls = bus.in_class;
        if (int'(bus.in_class) >= NUM_CLASS) cls = CW'(NUM_CLASS - 1);
        tgt    = bus.in_ugr_en ? UQ : QW'(cls);
        full   = (cnt_q[tgt] == C_FULL);
        accept = ready_q && !full;
        push   = bus.in_enque_en && accept;
    end

    // Urgent always wins; classes scan from 0 or from rr_ptr cyclically.
    always_comb begin
        for (int i = 0; i < NQ; i++) nonempty[i] = (cnt_q[i] != '0);
        sel   = UQ;
        found = 1'b0;
        idx   = 0;
        if (!nonempty[NUM_CLASS]) begin
            for (int k = 0; k < NUM_CLASS; k++) begin
                idx = (MODE == 1) ? (int'(rr_ptr_q) + k) % NUM_CLASS : k;
                if (!found && nonempty[idx]) begin
                    found = 1'b1;
                    sel   = QW'(idx);
                end
            end
        end
        load = (!out_valid_q || bus.out_deque_en) && (|nonempty);
    end

    always_comb begin
        ready_d = 1'b1;
        drop_d  = drop_q;
        if (bus.in_enque_en && ready_q && full && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
        push_i = 1'b0;
        pop_i  = 1'b0;
        for (int i = 0; i < NQ; i++) begin
            push_i      = push && (tgt == QW'(i));
            pop_i       = load && (sel == QW'(i));
            wr_ptr_d[i] = push_i ? wr_ptr_q[i] + P_ONE : wr_ptr_q[i];
            rd_ptr_d[i] = pop_i ? rd_ptr_q[i] + P_ONE : rd_ptr_q[i];
            cnt_d[i]    = cnt_q[i];
            if (push_i && !pop_i) cnt_d[i] = cnt_q[i] + C_ONE;
            if (pop_i && !push_i) cnt_d[i] = cnt_q[i] - C_ONE;
        end
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_class_d = out_class_q;
        out_ugr_d   = out_ugr_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = mem[sel][rd_ptr_q[sel]];
            out_ugr_d   = (sel == UQ);
            out_class_d = (sel == UQ) ? '0 : CW'(sel);
            if (sel != UQ)
                rr_ptr_d = (int'(sel) == NUM_CLASS - 1) ? '0 : CW'(sel) + R_ONE;
        end else if (bus.out_deque_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NQ; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rr_ptr_q    <= '0;
            drop_q      <= '0;
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_ugr_q   <= 1'b0;
            out_data_q  <= '0;
            out_class_q <= '0;
        end else begin
            for (int i = 0; i < NQ; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            rr_ptr_q    <= rr_ptr_d;
            drop_q      <= drop_d;
            ready_q     <= ready_d;
            out_valid_q <= out_valid_d;
            out_ugr_q   <= out_ugr_d;
            out_data_q  <= out_data_d;
            out_class_q <= out_class_d;
        end
    end

    // Storage needs no reset: occupancy counters gate every read.
    always_ff @(posedge clk) begin
        if (push) mem[tgt][wr_ptr_q[tgt]] <= bus.in_data;
    end

    assign bus.ready     = ready_q;
    assign bus.in_accept = accept;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_class = out_class_q;
    assign bus.out_ugr   = out_ugr_q;
    assign bus.drop_cnt  = drop_q;
endmodule
